ft_oh_arbiter: RTL and testbench
================================

# ft_oh_arbiter

Round-robin arbiter that shares the FT245 host interface's outgoing channel (`oh_ready`/`oh_en`, `out_status`/`out_address`/`out_data_count`/`out_data`) between `NUM_REQ` requesters, such as the Wishbone master response path and an interrupt notifier. Packets are granted atomically: the header word and all data words go to the host interface before the grant moves on. A per-word watchdog zero-pads a stalled packet so host-side framing is never broken.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, range 2–8.
- `TIMEOUT`, 1024: idle cycles allowed between words of a granted packet before padding starts. Must be ≥2.

Ports:
- `clk`  in  1  single clock, shared with the host interface.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rq_req`  in  NUM_REQ  level per requester; held high until that requester's `rq_done` pulses.
- `rq_status` / `rq_address` / `rq_data`  in  32*NUM_REQ  packed; requester i occupies bits [32i+31:32i].
- `rq_data_count`  in  28*NUM_REQ  packed header word count.
- `rq_valid`  in  NUM_REQ  current `rq_data` slice holds the next word.
- `rq_gnt`  out  NUM_REQ  one-hot; high for the whole packet.
- `rq_next`  out  NUM_REQ  1-cycle pulse: current word consumed, present the next one.
- `rq_done`  out  NUM_REQ  1-cycle pulse: packet finished.
- `oh_ready`  in  1  from the host interface.
- `oh_en`  out  1  1-cycle transfer strobe.
- `out_status` / `out_address` / `out_data`  out  32  registered, valid with `oh_en`.
- `out_data_count`  out  28  registered, valid with `oh_en`.
- `busy`  out  1  high whenever any grant is active.
- `timeout_err`  out  1  1-cycle pulse when padding starts.

## Operation
- States: IDLE, GRANT, HDR, GAP, DATA, PAD, RELEASE.
- IDLE: if any `rq_req` is set, pick a winner round-robin. Search starts at `rr_ptr`, and `rr_ptr` resets to 0. Assert `rq_gnt[w]`, then go to GRANT.
- GRANT: latch the winner's header fields into local copies.
  - `remaining` = `data_count` when `status[3:0]==4'hD`, otherwise 0.
  - Go to HDR.
- HDR: wait for `oh_ready & rq_valid[w]`. Then:
  - drive `out_*` from the latched header plus `rq_data[w]`;
  - pulse `oh_en` and `rq_next[w]`;
  - go to GAP.
- GAP: one cycle with no strobe, because `oh_ready` is registered low after `oh_en`.
  - `remaining==0`: go to RELEASE.
  - otherwise: go to DATA.
- DATA: wait for `oh_ready & rq_valid[w]`. Then:
  - `out_data <= rq_data[w]`; other `out_*` hold their values;
  - pulse `oh_en` and `rq_next[w]`;
  - `remaining <= remaining-1`;
  - go to GAP.
- Watchdog: a counter clears on every `oh_en`, counts in HDR and DATA while `rq_valid[w]` is low, and saturates at `TIMEOUT`.
  - On reaching `TIMEOUT` in DATA: pulse `timeout_err` and go to PAD.
  - In HDR the timeout is ignored; no header has been sent, so the arbiter waits indefinitely.
- PAD: the remaining words are sent with `out_data=0`, each still gated by `oh_ready` and separated by GAP. `rq_valid` is ignored and `rq_next` is not pulsed.
- RELEASE: pulse `rq_done[w]`, clear `rq_gnt`, set `rr_ptr <= w+1` (mod `NUM_REQ`), go to IDLE.
- Requester drops `rq_req` mid-packet: ignored. The packet completes, padded if the watchdog fires.
- Requests arriving during a grant wait for RELEASE. No preemption.
- Arithmetic: `remaining` is 28-bit and is never decremented below 0. Each packet produces exactly `remaining+1` `oh_en` pulses.

## Timing
- Reset values: `oh_en`, `rq_gnt`, `rq_next`, `rq_done`, `busy`, `timeout_err` = 0; all `out_*` = 0; state IDLE; `rr_ptr` 0; watchdog 0.
- Latency from `rq_req` rising in IDLE to the first `oh_en`: 3 cycles minimum (IDLE→GRANT→HDR strobe).
- `oh_en` is never high in two consecutive cycles. It only fires in a cycle where `oh_ready` was sampled high.
- `out_*`, `oh_en` and `rq_next` update on the same edge.
- `rq_done` to the next grant in IDLE: 1 cycle.
- Asynchronous reset mid-packet: every output clears immediately. The host interface is responsible for its own framing recovery.

## Structure
- Package `ft_arb_pkg`:
  - state enum and encodings;
  - `PKT_DATA_CODE = 4'hD`;
  - field widths (32 and 28).
- Sub-module `ft_rr_picker`: combinational round-robin one-hot select of request vector and pointer → winner index plus valid. Reused by any future input-side arbiter.

## Test plan
- Single read response: req0 with status `32'h0000_0002`, count 5 → exactly 1 `oh_en` carrying that status and address; `rq_done[0]` follows; `busy` falls.
- Write-type packet: status `...000D`, count 3, valid always high → 4 `oh_en` pulses, each spaced by at least one gap cycle and only when `oh_ready` is high; `out_data` = the 4 presented words in order.
- Contention: req0 and req1 both rise in the same cycle, each with a 1-word packet, repeated 4 times → grant order 0, 1, 0, 1; no interleaving of words within a packet.
- Stall: `TIMEOUT=16`, count 4, `rq_valid` held low after the 2nd word → `timeout_err` pulses once; 3 more `oh_en` pulses with `out_data=0`; `rq_done` still pulses.
- Back-pressure: `oh_ready` held low for 50 cycles during a packet → no `oh_en` and the watchdog stays clear (`rq_valid` high); resumes cleanly when `oh_ready` returns.
- `rst_n` asserted mid-DATA → outputs go to 0 asynchronously; after release, a new req1 is granted first with `rr_ptr` at 0.

Source files
------------

// File: rtl/ft_arb_pkg.sv
// ft_arb_pkg: shared types and constants for the FT245 outgoing-channel arbiter.
//   arb_state_t   - packet-sequencing states
//   PKT_DATA_CODE - status[3:0] value marking a packet that carries data words
//   WORD_W/CNT_W  - header word and data-count field widths
package ft_arb_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_HDR,
        S_GAP,
        S_DATA,
        S_PAD,
        S_RELEASE
    } arb_state_t;

    localparam logic [3:0] PKT_DATA_CODE = 4'hD;
    localparam int WORD_W = 32;
    localparam int CNT_W = 28;

    function automatic logic is_data_pkt(input logic [WORD_W-1:0] status);
        return status[3:0] == PKT_DATA_CODE;
    endfunction
endpackage

// File: rtl/ft_rr_picker.sv
// ft_rr_picker: combinational round-robin select, first set request at or after ptr.
//   req   - request vector
//   ptr   - index where the search starts
//   idx   - winning index (0 when nothing requests)
//   valid - any request set
module ft_rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    logic [N-1:0] rot;

    // rot[k] is req[(ptr+k) mod N]; the lowest set k is the winner
    always_comb begin
        rot = N'({req, req} >> ptr);
        idx = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) idx = IW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/ft_oh_arbiter.sv
// ft_oh_arbiter: round-robin, packet-atomic sharing of the FT245 outgoing channel.
//   clk, rst_n                      - clock, async active-low reset
//   rq_req/rq_valid                 - per-requester request level and word-valid
//   rq_status/address/data/count    - packed per-requester header and data
//   rq_gnt/rq_next/rq_done          - grant level, word-consumed and packet-done pulses
//   oh_ready/oh_en                  - host handshake and transfer strobe
//   out_status/address/count/data   - registered words to the host
//   busy/timeout_err                - grant active, padding-start pulse
module ft_oh_arbiter
    import ft_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         rq_req,
    input  logic [WORD_W*NUM_REQ-1:0]  rq_status,
    input  logic [WORD_W*NUM_REQ-1:0]  rq_address,
    input  logic [WORD_W*NUM_REQ-1:0]  rq_data,
    input  logic [CNT_W*NUM_REQ-1:0]   rq_data_count,
    input  logic [NUM_REQ-1:0]         rq_valid,
    output logic [NUM_REQ-1:0]         rq_gnt,
    output logic [NUM_REQ-1:0]         rq_next,
    output logic [NUM_REQ-1:0]         rq_done,
    input  logic                       oh_ready,
    output logic                       oh_en,
    output logic [WORD_W-1:0]          out_status,
    output logic [WORD_W-1:0]          out_address,
    output logic [CNT_W-1:0]           out_data_count,
    output logic [WORD_W-1:0]          out_data,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t state, nxt;
    logic [IW-1:0] w, rr_ptr, pick;
    logic pick_v, pad, v_w, xfer, fire, wd_cnt;
    logic [NUM_REQ-1:0][WORD_W-1:0] st_a, ad_a, da_a;
    logic [NUM_REQ-1:0][CNT_W-1:0] cn_a;
    logic [WORD_W-1:0] h_status, h_addr;
    logic [CNT_W-1:0] h_cnt, remaining;
    logic [WD_W-1:0] wd;
    logic [NUM_REQ-1:0] gnt_vec;

    assign st_a = rq_status;
    assign ad_a = rq_address;
    assign da_a = rq_data;
    assign cn_a = rq_data_count;
    assign busy = |rq_gnt;

    ft_rr_picker #(.N(NUM_REQ)) u_pick (
        .req  (rq_req),
        .ptr  (rr_ptr),
        .idx  (pick),
        .valid(pick_v)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = pick_v ? S_GRANT : S_IDLE;
            S_GRANT:   nxt = S_HDR;
            S_HDR:     nxt = xfer ? S_GAP : S_HDR;
            S_GAP:     nxt = (remaining == '0) ? S_RELEASE : pad ? S_PAD : S_DATA;
            S_DATA:    nxt = xfer ? S_GAP : fire ? S_PAD : S_DATA;
            S_PAD:     nxt = xfer ? S_GAP : S_PAD;
            S_RELEASE: nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // A header stall never times out: nothing has reached the host yet,
    // so there is no frame to complete.
    always_comb begin
        v_w = rq_valid[w];
        gnt_vec = ONE << w;
        wd_cnt = (state == S_HDR || state == S_DATA) && !v_w && wd != WD_W'(TIMEOUT);
        xfer = oh_ready && ((((state == S_HDR) || (state == S_DATA)) && v_w) || state == S_PAD);
        fire = state == S_DATA && !v_w && wd == WD_W'(TIMEOUT - 1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rq_gnt <= '0;
            rq_next <= '0;
            rq_done <= '0;
            oh_en <= 1'b0;
            timeout_err <= 1'b0;
            out_status <= '0;
            out_address <= '0;
            out_data_count <= '0;
            out_data <= '0;
            w <= '0;
            rr_ptr <= '0;
            pad <= 1'b0;
            wd <= '0;
            h_status <= '0;
            h_addr <= '0;
            h_cnt <= '0;
            remaining <= '0;
        end else begin
            oh_en <= xfer;
            rq_next <= (xfer && state != S_PAD) ? gnt_vec : '0;
            rq_done <= (state == S_RELEASE) ? gnt_vec : '0;
            timeout_err <= fire;
            wd <= xfer ? '0 : wd_cnt ? wd + 1'b1 : wd;
            case (state)
                S_IDLE: if (pick_v) begin
                    w <= pick;
                    rq_gnt <= ONE << pick;
                    pad <= 1'b0;
                end
                S_GRANT: begin
                    h_status <= st_a[w];
                    h_addr <= ad_a[w];
                    h_cnt <= cn_a[w];
                    remaining <= is_data_pkt(st_a[w]) ? cn_a[w] : '0;
                end
                S_HDR: if (xfer) begin
                    out_status <= h_status;
                    out_address <= h_addr;
                    out_data_count <= h_cnt;
                    out_data <= da_a[w];
                end
                S_DATA: begin
                    if (xfer) begin
                        out_data <= da_a[w];
                        remaining <= remaining - 1'b1;
                    end
                    if (fire) pad <= 1'b1;
                end
                S_PAD: if (xfer) begin
                    out_data <= '0;
                    remaining <= remaining - 1'b1;
                end
                S_RELEASE: begin
                    rq_gnt <= '0;
                    rr_ptr <= (w == IW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_ft_oh_arbiter.sv
// tb_ft_oh_arbiter: randomized bench for ft_oh_arbiter with a packet-level reference model.
module tb_ft_oh_arbiter;
    localparam int N = 3;
    localparam int TO = 16;
    localparam int QD = 128;

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] addr;
        logic [27:0] cnt;
        logic [15:0][31:0] w;
        int nwords;
        int stall_after;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] rq_req, rq_valid, rq_gnt, rq_next, rq_done;
    logic [32*N-1:0] rq_status, rq_address, rq_data;
    logic [28*N-1:0] rq_data_count;
    logic oh_ready, oh_en, busy, timeout_err;
    logic [31:0] out_status, out_address, out_data;
    logic [27:0] out_data_count;

    always #5 clk = ~clk;

    ft_oh_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rq_req(rq_req), .rq_status(rq_status),
        .rq_address(rq_address), .rq_data(rq_data), .rq_data_count(rq_data_count),
        .rq_valid(rq_valid), .rq_gnt(rq_gnt), .rq_next(rq_next), .rq_done(rq_done),
        .oh_ready(oh_ready), .oh_en(oh_en), .out_status(out_status),
        .out_address(out_address), .out_data_count(out_data_count), .out_data(out_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0, errors = 0;
    pkt_t pk [N][QD];
    pkt_t cur_pk [N];
    int head [N], tail [N], pos [N], hold [N], dly [N], req_tick [N];
    bit act [N];
    int vmax = 0, ready_mode = 0, tick_no = 0, pushed = 0, done_cnt = 0;
    logic [N-1:0] prev_req = '0, prev_gnt = '0;
    logic prev_en = 1'b0, prev_ready = 1'b0;
    int cur = -1, next_start = 0, hw = 0, tmo = 0, first_en_tick = 0;
    bit padded = 0;
    int win_log [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [31:0] st, input logic [27:0] c, input int stall);
        pkt_t p;
        p.status = st;
        p.addr = $urandom;
        p.cnt = c;
        for (int k = 0; k < 16; k++) p.w[k] = $urandom;
        p.nwords = (st[3:0] == 4'hD) ? int'(c) + 1 : 1;
        p.stall_after = stall;
        return p;
    endfunction

    task automatic push(input int i, input pkt_t p);
        pk[i][tail[i]] = p;
        tail[i]++;
        pushed++;
    endtask

    function automatic bit idle();
        bit r = (rq_gnt == '0);
        for (int i = 0; i < N; i++) r = r && !act[i] && head[i] == tail[i] && dly[i] == 0;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (act[i]) begin
                if (hold[i] > 0) hold[i]--;
                if (rq_next[i]) begin
                    pos[i]++;
                    hold[i] = $urandom_range(0, vmax);
                end
                if (rq_done[i]) begin
                    act[i] = 0;
                    dly[i] = 1 + $urandom_range(0, 3);
                end
            end else if (dly[i] > 0) dly[i]--;
            else if (head[i] != tail[i]) begin
                cur_pk[i] = pk[i][head[i]];
                head[i]++;
                act[i] = 1;
                pos[i] = 0;
                hold[i] = $urandom_range(0, vmax);
                req_tick[i] = tick_no;
            end
            rq_req[i] = act[i];
            rq_status[32*i +: 32] = cur_pk[i].status;
            rq_address[32*i +: 32] = cur_pk[i].addr;
            rq_data_count[28*i +: 28] = cur_pk[i].cnt;
            rq_data[32*i +: 32] = (pos[i] < 16) ? cur_pk[i].w[pos[i]] : 32'h0;
            rq_valid[i] = act[i] && hold[i] == 0 && pos[i] < cur_pk[i].nwords &&
                          (cur_pk[i].stall_after < 0 || pos[i] < cur_pk[i].stall_after);
        end
        oh_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    endtask

    task automatic monitor();
        pkt_t p;
        logic [N-1:0] exp_n;
        int e = -1;
        if (rq_gnt != '0 && prev_gnt == '0) begin
            for (int k = 0; k < N; k++)
                if (e < 0 && prev_req[(next_start + k) % N]) e = (next_start + k) % N;
            for (int k = 0; k < N; k++) if (rq_gnt[k]) cur = k;
            chk("gnt_onehot", $countones(rq_gnt), 1);
            chk("winner", cur, e);
            win_log.push_back(cur);
            next_start = (cur + 1) % N;
            hw = 0;
            tmo = 0;
            padded = 0;
        end
        exp_n = (oh_en && !padded && cur >= 0) ? N'(1) << cur : '0;
        chk("rq_next", rq_next, exp_n);
        if (oh_en) begin
            chk("en_gap", prev_en, 0);
            chk("en_ready", prev_ready, 1);
            chk("en_granted", cur >= 0, 1);
            if (cur >= 0) begin
                p = cur_pk[cur];
                chk("en_gnt", rq_gnt, N'(1) << cur);
                chk("status", out_status, p.status);
                chk("address", out_address, p.addr);
                chk("count", out_data_count, p.cnt);
                chk("data", out_data, padded ? 32'h0 : p.w[hw]);
                if (hw == 0) first_en_tick = tick_no;
                hw++;
            end
        end
        if (timeout_err) begin
            padded = 1;
            tmo++;
        end
        if (rq_done != '0) begin
            chk("done_granted", cur >= 0, 1);
            if (cur >= 0) begin
                p = cur_pk[cur];
                chk("done_who", rq_done, N'(1) << cur);
                chk("words", hw, p.nwords);
                chk("timeouts", tmo, (p.stall_after >= 0) ? 1 : 0);
                chk("gnt_clear", rq_gnt, 0);
            end
            done_cnt++;
            cur = -1;
        end
        prev_req = rq_req;
        prev_gnt = rq_gnt;
        prev_en = oh_en;
        prev_ready = oh_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!idle() && n < budget);
        chk("drain", idle(), 1);
        chk("busy_idle", busy, 0);
    endtask

    task automatic wait_word(input int who, input int words);
        int n = 0;
        while (!(cur == who && hw >= words) && n < 2000) begin
            tick();
            n++;
        end
        chk("reach", cur == who && hw >= words, 1);
    endtask

    initial begin
        int base;
        int aborted = 0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; pos[i] = 0; hold[i] = 0; dly[i] = 0; act[i] = 0;
            req_tick[i] = 0;
            cur_pk[i] = mk(32'h0, 28'h0, -1);
        end
        rq_req = '0; rq_valid = '0; rq_status = '0; rq_address = '0; rq_data = '0;
        rq_data_count = '0; oh_ready = 1'b0;
        repeat (3) tick();
        chk("rst_ctrl", {oh_en, rq_gnt, rq_next, rq_done, busy, timeout_err}, 0);
        chk("rst_data", out_status | out_address | out_data | {4'h0, out_data_count}, 0);
        #2 rst_n = 1'b1;

        // contention: simultaneous 1-word packets from requesters 0 and 1
        base = win_log.size();
        for (int r = 0; r < 4; r++) begin
            push(0, mk({$urandom_range(0, 255), 24'h0, 8'h02}, 28'($urandom), -1));
            push(1, mk({$urandom_range(0, 255), 24'h0, 8'h03}, 28'($urandom), -1));
            run_idle(200);
        end
        for (int k = 0; k < 8; k++) chk("rr_order", win_log[base + k], k % 2);

        // single read response and minimum latency
        push(0, mk(32'h0000_0002, 28'd5, -1));
        run_idle(100);
        chk("latency", first_en_tick - req_tick[0], 3);

        // write-type packet with random host ready
        ready_mode = 1;
        push(0, mk(32'h0000_000D, 28'd3, -1));
        run_idle(200);

        // stall after two words forces padding
        ready_mode = 0;
        push(0, mk(32'h0000_010D, 28'd4, 2));
        run_idle(300);

        // back-pressure: host not ready for 50 cycles mid-packet
        push(1, mk(32'h0000_020D, 28'd6, -1));
        wait_word(1, 2);
        ready_mode = 2;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("bp_no_en", oh_en, 0);
            chk("bp_no_tmo", timeout_err, 0);
        end
        chk("bp_busy", busy, 1);
        ready_mode = 0;
        run_idle(200);

        // random traffic
        vmax = 3;
        ready_mode = 1;
        for (int k = 0; k < 40; k++)
            push($urandom_range(0, N - 1),
                 mk({28'($urandom), ($urandom_range(0, 1) != 0) ? 4'hD : 4'($urandom_range(0, 12))},
                    28'($urandom_range(0, 8)), -1));
        run_idle(20000);

        // asynchronous reset mid-packet; pointer must restart at 0
        vmax = 0;
        ready_mode = 0;
        push(1, mk(32'h0000_000D, 28'd2, -1));
        run_idle(100);
        push(2, mk(32'h0000_000D, 28'd8, -1));
        wait_word(2, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {oh_en, rq_gnt, rq_next, rq_done, busy, timeout_err}, 0);
        chk("arst_data", out_status | out_address | out_data | {4'h0, out_data_count}, 0);
        for (int i = 0; i < N; i++) begin
            aborted += (act[i] ? 1 : 0) + (tail[i] - head[i]);
            act[i] = 0; head[i] = tail[i]; dly[i] = 0;
        end
        rq_req = '0;
        rq_valid = '0;
        cur = -1; next_start = 0; prev_gnt = '0; prev_req = '0; prev_en = 1'b0; padded = 0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        base = win_log.size();
        push(1, mk(32'h0000_0005, 28'd0, -1));
        push(2, mk(32'h0000_0006, 28'd0, -1));
        run_idle(200);
        chk("rst_rr_first", win_log[base], 1);
        chk("rst_rr_second", win_log[base + 1], 2);
        chk("pkts", done_cnt, pushed - aborted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
